viterbi_decoder_param: RTL
==========================

Name: viterbi_decoder_param

Overview:
- Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes. Successor to the fixed K=3 channel decoder.
- Constraint length, generator polynomials, survivor depth and metric width are configurable.
- Adds an input-valid handshake, a synchronous restart, and a best-path-metric output for link-quality monitoring.
- Sits between the demodulator (2-bit symbol per accepted beat) and the data sink.

Parameters:
- K, 3, constraint length (3..7); number of states NS = 2^(K-1).
- G0, 3'b111, first generator; K bits, MSB taps the newest bit.
- G1, 3'b101, second generator; K bits.
- TB_DEPTH, 15, survivor register length in bits, and the decode latency in symbols (>= 2).
- PM_W, 6, path-metric width in bits.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous restart of the decoder; has priority over in_valid.
- in_valid  in  1  symbol strobe; one symbol is accepted per high cycle.
- in  in  2  received symbol {c0,c1}; c0 is the G0 output, c1 is the G1 output.
- o  out  1  decoded bit.
- enable  out  1  one-cycle strobe; o is valid while it is high.
- best_pm  out  PM_W  metric of the best state after the last accepted symbol.

Behaviour:
- Encoder convention:
  - Shift vector s = {u_t, u_(t-1), ..., u_(t-K+1)}.
  - c0 = ^(s & G0); c1 = ^(s & G1).
  - State = {u_(t-1) .. u_(t-K+1)}; start state is 0.
- Trellis:
  - Next state n has predecessors p_b = {n[K-3:0], b} for b = 0,1.
  - Input bit u = n[K-2].
  - Expected symbol is computed from s = {n, b}.
- Branch metric: Hamming distance between in and the expected symbol (0..2).
- ACS, all NS states in one cycle per accepted symbol:
  - cand_b = pm[p_b] + bm_b.
  - Select the smaller candidate; on a tie, select b = 0.
  - Additions saturate at 2^PM_W - 1.
- Survivors (register exchange): path[n] <= {path[p_sel][TB_DEPTH-2:0], u}.
- Best state: the minimum new metric; on a tie, the lowest index.
- Normalisation: if the minimum new metric >= 2^(PM_W-1), subtract 2^(PM_W-1) from every new metric in the same cycle.
- Outputs:
  - Cycle after an accepted symbol: o = path[best][TB_DEPTH-1], best_pm = best metric (after normalisation).
  - enable = 1 for that cycle only if at least TB_DEPTH symbols have been accepted since the last reset/sync_clr.
  - enable is 0 in every other cycle; o and best_pm hold their values.
- Latency: the bit carried by symbol j emerges with the enable that follows symbol j+TB_DEPTH-1. The first enable (symbol count = TB_DEPTH) carries u_0.
- in_valid low: no state change; gaps of any length are legal.
- Fill counter: saturates at TB_DEPTH.
- reset low (async, any time, including mid-stream):
  - pm[0] = 0; pm[1..NS-1] = 2^(PM_W-2).
  - All paths 0, fill count 0, o = 0, enable = 0, best_pm = 0.
- sync_clr high: same values as reset, applied on the clock edge; any symbol presented in that cycle is discarded.

Decomposition:
- Package viterbi_pkg:
  - Function for expected symbol from (s, G0, G1).
  - Hamming-distance function.
  - Saturating-add function.
  - Localparams NS, PM_INIT = 2^(PM_W-2), PM_HALF = 2^(PM_W-1).
- Sub-module viterbi_acs: one butterfly node. Takes the two predecessor metrics, the two branch metrics and the two predecessor paths; returns the new metric and the new path. Generated NS times in the top level.
- Top level holds the metric and path registers, min/argmin tree, normaliser, fill counter and output registers.

Test Plan:
- Clean stream, defaults:
  - Stimulus: bits 1,0,1,1,0,0 encode to 11,10,00,01,01,11; follow with 15 symbols 00, all with in_valid=1.
  - Required: exactly 6 enable pulses in the first 6 decoded outputs, o = 1,0,1,1,0,0; best_pm = 0 throughout.
- Single error:
  - Stimulus: same stream with the third symbol 00 changed to 10.
  - Required: o = 1,0,1,1,0,0 unchanged; best_pm = 1 from the third symbol onward.
- Valid gaps:
  - Stimulus: same clean stream with in_valid low for 1-7 random cycles between symbols, and `in` driven to garbage during gaps.
  - Required: identical o sequence; enable only one cycle after accepted symbols.
- sync_clr mid-stream:
  - Stimulus: assert sync_clr after 20 symbols, then replay the clean stream.
  - Required: enable stays low until 15 new symbols have been accepted, then o = 1,0,1,1,0,0.
- Async reset mid-stream:
  - Stimulus: pull reset low between clock edges.
  - Required: o, enable and best_pm become 0 immediately, with no clock edge; after release, decoding behaves exactly as in the clean-stream case.
- Normalisation:
  - Stimulus: 200 symbols of random noise.
  - Required: no metric wraps; best_pm < 32 at all times; after switching to the clean stream the next decoded bits are correct.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared helpers and sizing for the parametrised rate-1/2 hard-decision Viterbi decoder.
// Helper functions work on fixed wide vectors so that any legal K / PM_W fits.
package viterbi_pkg;

  localparam int S_W = 8;
  localparam int M_W = 16;

  function automatic int ns_of(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int pm_init_of(input int w);
    return 1 << (w - 2);
  endfunction

  function automatic int pm_half_of(input int w);
    return 1 << (w - 1);
  endfunction

  // Values for the default configuration (K=3, PM_W=6)
  localparam int NS      = ns_of(3);
  localparam int PM_INIT = pm_init_of(6);
  localparam int PM_HALF = pm_half_of(6);

  // Expected {c0,c1} for shift vector s = {u_t .. u_(t-K+1)}
  function automatic logic [1:0] exp_sym(input logic [S_W-1:0] s,
                                         input logic [S_W-1:0] g0,
                                         input logic [S_W-1:0] g1);
    return {^(s & g0), ^(s & g1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [M_W-1:0] sat_add(input logic [M_W-1:0] a,
                                             input logic [1:0]     b,
                                             input logic [M_W-1:0] max_v);
    logic [M_W:0] sum;
    sum = {1'b0, a} + {{(M_W - 1){1'b0}}, b};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end else begin
      return sum[M_W-1:0];
    end
  endfunction

endpackage

// File: rtl/viterbi_if.sv
// Symbol-in / decoded-bit-out bundle between demodulator, decoder and data sink.
interface viterbi_if #(parameter int PM_W = 6);
  logic            sync_clr;
  logic            in_valid;
  logic [1:0]      in;
  logic            o;
  logic            enable;
  logic [PM_W-1:0] best_pm;

  modport master (output sync_clr, in_valid, in, input o, enable, best_pm);
  modport slave  (input sync_clr, in_valid, in, output o, enable, best_pm);
endinterface

// File: rtl/viterbi_acs.sv
// One add-compare-select node: picks the cheaper of two predecessors and extends its survivor.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W     = 6,
  parameter int TB_DEPTH = 15
) (
  input  logic [PM_W-1:0]     pm0_i,
  input  logic [PM_W-1:0]     pm1_i,
  input  logic [1:0]          bm0_i,
  input  logic [1:0]          bm1_i,
  input  logic [TB_DEPTH-2:0] path0_i,
  input  logic [TB_DEPTH-2:0] path1_i,
  input  logic                u_i,
  output logic [PM_W-1:0]     pm_o,
  output logic [TB_DEPTH-1:0] path_o
);

  localparam logic [M_W-1:0] PM_MAX = M_W'((1 << PM_W) - 1);

  logic [PM_W-1:0] cand0_s;
  logic [PM_W-1:0] cand1_s;

  // Saturating candidates; a tie keeps predecessor b = 0
  always_comb begin
    cand0_s = PM_W'(sat_add(M_W'(pm0_i), bm0_i, PM_MAX));
    cand1_s = PM_W'(sat_add(M_W'(pm1_i), bm1_i, PM_MAX));
    if (cand1_s < cand0_s) begin
      pm_o   = cand1_s;
      path_o = {path1_i, u_i};
    end else begin
      pm_o   = cand0_s;
      path_o = {path0_i, u_i};
    end
  end

endmodule

// File: rtl/viterbi_decoder_param.sv
// Parametrised hard-decision Viterbi decoder: full-parallel ACS, register-exchange survivors,
// metric normalisation and a best-path metric for link-quality monitoring.
module viterbi_decoder_param
  import viterbi_pkg::*;
#(
  parameter int           K        = 3,
  parameter logic [K-1:0] G0       = 3'b111,
  parameter logic [K-1:0] G1       = 3'b101,
  parameter int           TB_DEPTH = 15,
  parameter int           PM_W     = 6
) (
  input  logic    clk,
  input  logic    reset,
  viterbi_if.slave bus
);

  localparam int                NS_L      = ns_of(K);
  localparam int                SEL_W     = K - 1;
  localparam logic [PM_W-1:0]   PM_INIT_V = PM_W'(pm_init_of(PM_W));
  localparam logic [PM_W-1:0]   PM_HALF_V = PM_W'(pm_half_of(PM_W));
  localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(TB_DEPTH);

  // The survivor MSB is only ever needed for the output bit, which is taken
  // straight from the next-state paths, so the stored paths drop it.
  logic [PM_W-1:0]     pm_q    [NS_L];
  logic [TB_DEPTH-2:0] path_q  [NS_L];
  logic [PM_W-1:0]     pm_d    [NS_L];
  logic [PM_W-1:0]     pm_n_s  [NS_L];
  logic [TB_DEPTH-1:0] path_d  [NS_L];
  logic [1:0]          bm0_s   [NS_L];
  logic [1:0]          bm1_s   [NS_L];
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                o_q, o_d, enable_q, en_d, norm_s;
  logic [PM_W-1:0]     best_pm_q, best_pm_d, min_s;
  logic [SEL_W-1:0]    best_s;

  for (genvar n = 0; n < NS_L; n++) begin : g_node
    localparam int             P0 = (2 * n) % NS_L;
    localparam int             P1 = P0 + 1;
    localparam logic [S_W-1:0] S0 = S_W'(2 * n);
    localparam logic [S_W-1:0] S1 = S_W'(2 * n + 1);
    localparam logic           U  = 1'(n >> (K - 2));

    assign bm0_s[n] = hamming2(bus.in, exp_sym(S0, S_W'(G0), S_W'(G1)));
    assign bm1_s[n] = hamming2(bus.in, exp_sym(S1, S_W'(G0), S_W'(G1)));

    viterbi_acs #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) u_acs (
      .pm0_i   (pm_q[P0]),
      .pm1_i   (pm_q[P1]),
      .bm0_i   (bm0_s[n]),
      .bm1_i   (bm1_s[n]),
      .path0_i (path_q[P0]),
      .path1_i (path_q[P1]),
      .u_i     (U),
      .pm_o    (pm_d[n]),
      .path_o  (path_d[n])
    );
  end

  // Minimum metric and its lowest-index state
  always_comb begin
    min_s  = pm_d[0];
    best_s = {SEL_W{1'b0}};
    for (int i = 1; i < NS_L; i++) begin
      best_s = (pm_d[i] < min_s) ? SEL_W'(i) : best_s;
      min_s  = (pm_d[i] < min_s) ? pm_d[i] : min_s;
    end
  end

  // Normalisation, fill count and output next-state
  always_comb begin
    norm_s = (min_s >= PM_HALF_V);
    for (int i = 0; i < NS_L; i++) begin
      pm_n_s[i] = norm_s ? (pm_d[i] - PM_HALF_V) : pm_d[i];
    end
    best_pm_d = norm_s ? (min_s - PM_HALF_V) : min_s;
    o_d       = path_d[best_s][TB_DEPTH-1];
    fill_d    = (fill_q == FILL_MAX) ? fill_q : (fill_q + FILL_W'(1));
    en_d      = (fill_q >= (FILL_MAX - FILL_W'(1)));
  end

  // Metric/survivor state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NS_L; i++) begin
        pm_q[i]   <= (i == 0) ? {PM_W{1'b0}} : PM_INIT_V;
        path_q[i] <= {(TB_DEPTH - 1){1'b0}};
      end
      fill_q    <= {FILL_W{1'b0}};
      o_q       <= 1'b0;
      enable_q  <= 1'b0;
      best_pm_q <= {PM_W{1'b0}};
    end else if (bus.sync_clr) begin
      for (int i = 0; i < NS_L; i++) begin
        pm_q[i]   <= (i == 0) ? {PM_W{1'b0}} : PM_INIT_V;
        path_q[i] <= {(TB_DEPTH - 1){1'b0}};
      end
      fill_q    <= {FILL_W{1'b0}};
      o_q       <= 1'b0;
      enable_q  <= 1'b0;
      best_pm_q <= {PM_W{1'b0}};
    end else if (bus.in_valid) begin
      for (int i = 0; i < NS_L; i++) begin
        pm_q[i]   <= pm_n_s[i];
        path_q[i] <= path_d[i][TB_DEPTH-2:0];
      end
      fill_q    <= fill_d;
      o_q       <= o_d;
      enable_q  <= en_d;
      best_pm_q <= best_pm_d;
    end else begin
      enable_q  <= 1'b0;
    end
  end

  assign bus.o       = o_q;
  assign bus.enable  = enable_q;
  assign bus.best_pm = best_pm_q;

endmodule
